r2r_sar_adc: RTL and testbench
==============================

Name: r2r_sar_adc

Overview:
- Successive-approximation controller for the R2R-ladder ADC.
- Drives the 8-bit code onto the R2R ladder pins, samples the external analog comparator and builds the conversion result bit by bit, MSB first.
- raw_data is the 8-bit raw R2R code consumed by the menu/display data selector and by the averaging/scaling path; data_valid is its sample strobe.

Parameters:
- DATA_WIDTH, 8, ladder resolution in bits; equals the width of the raw R2R code.
- SETTLE_CYCLES, 100, clocks the ladder and comparator settle after each code change (1 us at 100 MHz); legal range ≥1, elaboration error otherwise.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; level-sensitive, sampled only in IDLE.
- comparator_in  input  1  1 = analog input ≥ ladder voltage.
- dac_code  output  DATA_WIDTH  code driven to the R2R ladder pins.
- raw_data  output  DATA_WIDTH  last completed conversion result.
- data_valid  output  1  one-cycle pulse when raw_data updates.
- busy  output  1  high from start acceptance through the DONE cycle.

Behaviour:
- One clock; reset is synchronous and active-high. All outputs registered.
- Reset values:
  - state = IDLE.
  - dac_code, raw_data, data_valid, busy all 0.
  - Bit index = DATA_WIDTH-1; settle count = 0.
- Reset mid-conversion aborts immediately and leaves no partial result on raw_data.
- States: IDLE, SETTLE, DECIDE, DONE.
- IDLE, start=1 at edge k:
  - result <= 0; dac_code <= 1<<(DATA_WIDTH-1); bit index <= DATA_WIDTH-1; count <= 0; busy <= 1; go to SETTLE.
- SETTLE:
  - Count increments each cycle.
  - At count == SETTLE_CYCLES-1, go to DECIDE; dac_code is held throughout.
- DECIDE:
  - If comparator_in=1, keep the trial bit in result; else clear it.
  - If bit index > 0: drive dac_code = result | 1<<(index-1), decrement index, clear count, go to SETTLE.
  - If bit index == 0: go to DONE.
- DONE:
  - raw_data <= final result; data_valid = 1 for exactly this cycle.
  - dac_code holds the final result.
  - busy deasserts on the next edge, which returns the FSM to IDLE.
- Latency:
  - Each bit takes SETTLE_CYCLES+1 clocks.
  - data_valid is high in the cycle beginning DATA_WIDTH*(SETTLE_CYCLES+1) edges after edge k.
- start while busy (SETTLE, DECIDE or DONE) is ignored; there is no queuing.
- start held high gives back-to-back conversions: the next conversion is accepted in the IDLE cycle after DONE. Conversion-to-conversion period is DATA_WIDTH*(SETTLE_CYCLES+1)+2 clocks.
- raw_data is stable between data_valid pulses.
- Boundaries:
  - comparator_in constantly 1 → 0xFF.
  - comparator_in constantly 0 → 0x00.
  - No wrap-around, no arithmetic overflow (bitwise OR only).

Optional Feature:
- Macro: R2R_COMP_SYNC_EN.
- Defined:
  - comparator_in passes through a two-flop synchronizer before DECIDE samples it.
  - The SETTLE exit threshold becomes SETTLE_CYCLES+1, giving 2 extra clocks per bit for synchronizer latency.
  - Per-bit time is SETTLE_CYCLES+3; conversion latency is DATA_WIDTH*(SETTLE_CYCLES+3).
- Undefined: comparator_in is sampled directly in DECIDE; the board guarantees the comparator is synchronous to clk.

Decomposition:
- Package r2r_pkg:
  - R2R_WIDTH = 8.
  - Enum sar_state_t {IDLE, SETTLE, DECIDE, DONE}.
  - Type r2r_code_t = logic [R2R_WIDTH-1:0].
- Sub-module r2r_settle_timer:
  - Loadable down-counter with clear and a done flag.
  - Parameterized on cycle count.
  - Instantiated once; the FSM clears it on every dac_code change.

Test Plan (bench models comparator_in = (vin_code ≥ dac_code), SETTLE_CYCLES=4):
- vin_code=0xA5, pulse start → dac_code trials 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5; raw_data=0xA5 with data_valid high 40 clocks after acceptance, for exactly 1 cycle.
- vin_code=0x00, then 0xFF → raw_data=0x00, then 0xFF; busy low in the cycle after each DONE.
- start held high, vin_code steps 0x10→0x3C between conversions → data_valid pulses 42 clocks apart, raw_data 0x10 then 0x3C.
- Pulse start again at clocks 5 and 20 of a conversion → ignored; exactly one data_valid pulse and the result is unchanged.
- reset asserted at clock 17 of a conversion → next cycle state IDLE, dac_code=0, busy=0, no data_valid; a fresh start then converts correctly.
- With R2R_COMP_SYNC_EN defined, vin_code=0x5A → raw_data=0x5A, data_valid at 56 clocks.

Source files
------------

// File: rtl/r2r_pkg.sv
// Shared types for the R2R-ladder SAR ADC controller.
package r2r_pkg;

  localparam int R2R_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE,
    DONE
  } sar_state_t;

  typedef logic [R2R_WIDTH-1:0] r2r_code_t;

endpackage

// File: rtl/r2r_sar_adc_settle_timer.sv
// Settle timer: a loadable down-counter. Loading starts a settle window of
// CYCLES clocks; done is high in the last cycle of that window and stays high
// until the next load. clear parks the counter at zero.
module r2r_settle_timer #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  output logic done
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count down to zero after each load; load wins over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (clear) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/r2r_sar_adc.sv
// Successive-approximation controller for the R2R-ladder ADC.
// Drives trial codes onto the ladder, samples the external comparator and
// builds the result MSB first. raw_data/data_valid carry the finished code.
// Optional build macro R2R_COMP_SYNC_EN: puts comparator_in through a two-flop
// synchronizer and stretches each settle window by two clocks to cover its
// latency.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; busy low
//   SETTLE | trial code on the ladder, waiting for ladder/comparator to settle
//   DECIDE | keep or drop the trial bit, then set up the next trial or finish
//   DONE   | result on raw_data, data_valid high for this cycle only
module r2r_sar_adc
  import r2r_pkg::*;
#(
  parameter int DATA_WIDTH    = R2R_WIDTH,
  parameter int SETTLE_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  comparator_in,
  output logic [DATA_WIDTH-1:0] dac_code,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  data_valid,
  output logic                  busy
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("r2r_sar_adc: SETTLE_CYCLES must be at least 1");
  end

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DATA_WIDTH-1:0] MSB_CODE = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DATA_WIDTH - 1);

`ifdef R2R_COMP_SYNC_EN
  localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
`else
  localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif

  logic comp_s;

`ifdef R2R_COMP_SYNC_EN
  logic [1:0] comp_sync;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk) begin
    if (reset) begin
      comp_sync <= '0;
    end else begin
      comp_sync <= {comp_sync[0], comparator_in};
    end
  end

  assign comp_s = comp_sync[1];
`else
  assign comp_s = comparator_in;
`endif

  sar_state_t            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] dac_d, raw_d, decided;
  logic                  valid_d, busy_d;
  logic                  tmr_load, tmr_clear, tmr_done;

  r2r_settle_timer #(
    .CYCLES(SETTLE_LEN)
  ) u_settle_timer (
    .clk  (clk),
    .reset(reset),
    .clear(tmr_clear),
    .load (tmr_load),
    .done (tmr_done)
  );

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= TOP_IDX;
      dac_code   <= '0;
      raw_data   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dac_code   <= dac_d;
      raw_data   <= raw_d;
      data_valid <= valid_d;
      busy       <= busy_d;
    end
  end

  // Next-state and next-output logic; the settle timer is reloaded on every
  // dac_code change.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dac_d     = dac_code;
    raw_d     = raw_data;
    valid_d   = 1'b0;
    busy_d    = busy;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    // dac_code already holds result | trial bit, so the decision only
    // rewrites the trial bit position.
    decided        = dac_code;
    decided[idx_q] = comp_s;

    unique case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        busy_d    = 1'b0;
        if (start) begin
          dac_d    = MSB_CODE;
          idx_d    = TOP_IDX;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_done) begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        if (idx_q != '0) begin
          dac_d    = decided | (DATA_WIDTH'(1) << (idx_q - 1'b1));
          idx_d    = idx_q - 1'b1;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end else begin
          dac_d   = decided;
          raw_d   = decided;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_r2r_sar_adc.sv
// Scoreboard bench for r2r_sar_adc with an ideal comparator model
// (comparator_in = vin >= dac_code).
module tb_r2r_sar_adc;
  import r2r_pkg::*;

  localparam int S = 4;
  localparam int W = 8;
`ifdef R2R_COMP_SYNC_EN
  localparam int P = S + 3;
`else
  localparam int P = S + 1;
`endif
  localparam int LAT = W * P;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       comparator_in;
  logic [7:0] dac_code, raw_data;
  logic       data_valid, busy;
  r2r_code_t  vin = '0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic rst_at_edge = 1'b1;

  logic [7:0] exp_q[$];
  logic [7:0] trial_q[$];

  // monitor state
  int         off = -1;
  logic       busy_prev = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] last_raw = '0;

  always #5 clk = ~clk;

  assign comparator_in = (vin >= dac_code);

  r2r_sar_adc #(
    .DATA_WIDTH   (W),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .comparator_in(comparator_in),
    .dac_code     (dac_code),
    .raw_data     (raw_data),
    .data_valid   (data_valid),
    .busy         (busy)
  );

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: binary search of an ideal comparator; result must equal vin.
  task automatic push_conv(input logic [7:0] v);
    logic [7:0] code, trial;
    code = '0;
    for (int b = W - 1; b >= 0; b--) begin
      trial = code | (8'(1) << b);
      trial_q.push_back(trial);
      if (v >= trial) code = trial;
    end
    exp_q.push_back(v);
  endtask

  // Monitor: checks trial codes, results, latency, busy and reset behaviour.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_at_edge) begin
      chk("reset_dac_code", dac_code, 0);
      chk("reset_busy", busy, 0);
      chk("reset_data_valid", data_valid, 0);
      chk("reset_raw_data", raw_data, 0);
      exp_q.delete();
      trial_q.delete();
      off        = -1;
      busy_prev  = 1'b0;
      prev_valid = 1'b0;
      last_raw   = '0;
    end else begin
      if (prev_valid) chk("busy_after_done", busy, 0);
      if (busy && !busy_prev) off = 0;
      else if (off >= 0) off++;
      if (off >= 0 && off < LAT && (off % P) == 0) begin
        if (trial_q.size() == 0) flag("unexpected_trial_code");
        else begin
          e = trial_q.pop_front();
          chk("dac_trial", dac_code, e);
        end
      end
      if (data_valid) begin
        if (exp_q.size() == 0) flag("unexpected_data_valid");
        else begin
          e = exp_q.pop_front();
          chk("raw_data", raw_data, e);
          chk("latency", off, LAT);
          last_raw = e;
        end
        off = -1;
      end else begin
        chk("raw_stable", raw_data, last_raw);
      end
      prev_valid = data_valid;
      busy_prev  = busy;
    end
  end

  task automatic convert(input logic [7:0] v);
    vin = v;
    push_conv(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    chk({name, "_pending_results"}, exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      trial_q.delete();
    end
  endtask

  task automatic wait_valid(output int t);
    t = -1;
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk);
      #1;
      if (data_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) flag("data_valid_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    logic [7:0] v;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    convert(8'hA5); wait_done("a5");
    convert(8'h00); wait_done("zero");
    convert(8'hFF); wait_done("ones");
    convert(8'h5A); wait_done("5a");

    // start held high: back-to-back conversions
    vin = 8'h10;
    push_conv(8'h10);
    start = 1'b1;
    wait_valid(t1);
    vin = 8'h3C;
    push_conv(8'h3C);
    wait_valid(t2);
    start = 1'b0;
    chk("b2b_period", t2 - t1, LAT + 2);
    wait_done("b2b");

    // start pulses while busy must be ignored
    convert(8'h6E);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignored_start");
    repeat (LAT + 10) @(posedge clk);
    #1;

    // reset part-way through a conversion, then a clean conversion
    convert(8'h33);
    repeat (17) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    convert(8'h4B); wait_done("after_reset");

    // random codes with random idle gaps
    for (int n = 0; n < 24; n++) begin
      v = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      convert(v);
      wait_done("random");
    end

    repeat (20) @(posedge clk);
    #1;
    chk("final_results_drained", exp_q.size(), 0);
    chk("final_trials_drained", trial_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
